hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives the PC write enable, the IF/ID write/flush controls and
//  the ID/EX bubble and global hold. Detects load-use hazards (ID vs EX), applies taken-branch flushes

---
 rtl/hazard_stall_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencer for the 5-stage core. Generates the PC write enable,
//   the IF/ID write/flush controls, the ID/EX bubble and the global pipe hold.
//   It handles three things:
//     - load-use hazards between the ID and EX instructions
//     - taken-branch flushes resolved in EX
//     - a freeze of the whole pipe while data memory is busy
//
// Configuration macro:
//   HAZARD_PERF_EN  when defined, stall_cnt/flush_cnt are saturating counters
//                   cleared by perf_clr. When undefined, there are no counter
//                   flops, both outputs read 0 and perf_clr is ignored.
//
// Parameters:
//   REG_AW        register-address width of the rs/rt/rd fields
//   LOAD_STALL    stall cycles per load-use hazard (1..7)
//   FLUSH_CYCLES  bubble cycles per taken branch (1..3)
//   CNT_W         width of the performance counters
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   id_rs, id_rt              source registers of the ID instruction
//   id_use_rs, id_use_rt      ID instruction actually reads rs / rt
//   ex_mem_read, ex_rd        EX instruction is a load, and its destination
//   branch_taken              taken branch/jump resolved in EX this cycle
//   mem_busy                  data memory not ready; freeze the pipe
//   perf_clr                  synchronous clear of the perf counters
//   pc_wr, if_id_wr           PC / IF/ID load enables
//   if_id_flush               IF/ID clear to NOP (wins over if_id_wr)
//   id_ex_bubble              ID/EX loads NOP control
//   pipe_hold                 freeze ID/EX, EX/MEM and MEM/WB
//   stall_cnt, flush_cnt      load-use stall cycles / taken-branch flush events
module hazard_stall_ctrl #(
  parameter int REG_AW       = 3,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              perf_clr,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_hold,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // cnt holds the cycles still to go after the current one, so the first
  // stall/flush cycle is the one that detects the event.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       hazard;
  logic       stall_ev;
  logic       flush_ev;

  // Register 0 is hardwired zero, so a load targeting it can never hazard.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) ||
                   (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // mem_busy freezes everything; otherwise a taken branch overrides any
  // stall in progress, and a hazard is only recognised from RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    if (!mem_busy) begin
      if (branch_taken) begin
        flush_ev = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_INIT;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              stall_ev = 1'b1;
              if (LOAD_STALL > 1) begin
                state_nxt = LU_STALL;
                cnt_nxt   = STALL_INIT;
              end
            end
          end
          LU_STALL: begin
            stall_ev = 1'b1;
            if (cnt <= 3'd1) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - 3'd1;
            end
          end
          FLUSH: begin
            if (cnt <= 3'd1) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - 3'd1;
            end
          end
          default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Outputs are forced low while rst is high so the pipe sees a clean idle.
  always_comb begin
    pc_wr        = 1'b0;
    if_id_wr     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pipe_hold = 1'b1;
      end else if (branch_taken) begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              id_ex_bubble = 1'b1;
            end else begin
              pc_wr    = 1'b1;
              if_id_wr = 1'b1;
            end
          end
          LU_STALL: begin
            id_ex_bubble = 1'b1;
          end
          FLUSH: begin
            pc_wr        = 1'b1;
            if_id_wr     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end
          default: begin
            pc_wr = 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_ev && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_perf;

  assign unused_perf = perf_clr ^ stall_ev ^ flush_ev;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Scoreboard bench for hazard_stall_ctrl. The driver applies directed and
//   random stimulus, runs a cycle-level reference model (remaining stall /
//   flush cycle counts) and queues the expected outputs; an independent
//   monitor pops and compares once per cycle.
module tb_hazard_stall_ctrl;

  localparam int REG_AW       = 3;
  localparam int LOAD_STALL   = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct packed {
    logic             pc_wr;
    logic             if_id_wr;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic              ex_mem_read = 1'b0;
  logic [REG_AW-1:0] ex_rd = '0;
  logic              branch_taken = 1'b0;
  logic              mem_busy = 1'b0;
  logic              perf_clr = 1'b0;
  logic              pc_wr;
  logic              if_id_wr;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pipe_hold;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model state: cycles still owed to a stall or a flush.
  int m_stall_left = 0;
  int m_flush_left = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  hazard_stall_ctrl #(
    .REG_AW(REG_AW),
    .LOAD_STALL(LOAD_STALL),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .mem_busy(mem_busy),
    .perf_clr(perf_clr),
    .pc_wr(pc_wr),
    .if_id_wr(if_id_wr),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs on the falling edge, predicts that cycle's
  // outputs and advances the model to the state after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rt, input logic urs,
                               input logic urt, input logic mr,
                               input logic [REG_AW-1:0] rd, input logic bt,
                               input logic mb, input logic pclr);
    exp_t e;
    bit   haz;
    bit   stall_ev;
    bit   flush_ev;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_mem_read = mr; ex_rd = rd; branch_taken = bt; mem_busy = mb;
    perf_clr = pclr;
    haz = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    e = '0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (r) begin
      m_stall_left = 0;
      m_flush_left = 0;
      m_stall_cnt  = 0;
      m_flush_cnt  = 0;
    end else begin
      if (PERF_EN) begin
        e.stall_cnt = CNT_W'(m_stall_cnt);
        e.flush_cnt = CNT_W'(m_flush_cnt);
      end
      if (mb) begin
        e.pipe_hold = 1'b1;
      end else if (bt) begin
        {e.pc_wr, e.if_id_wr, e.if_id_flush, e.id_ex_bubble} = 4'b1111;
        flush_ev = 1'b1;
        m_flush_left = FLUSH_CYCLES - 1;
        m_stall_left = 0;
      end else if (m_flush_left > 0) begin
        {e.pc_wr, e.if_id_wr, e.if_id_flush, e.id_ex_bubble} = 4'b1111;
        m_flush_left--;
      end else if (m_stall_left > 0) begin
        e.id_ex_bubble = 1'b1;
        stall_ev = 1'b1;
        m_stall_left--;
      end else if (haz) begin
        e.id_ex_bubble = 1'b1;
        stall_ev = 1'b1;
        m_stall_left = LOAD_STALL - 1;
      end else begin
        e.pc_wr    = 1'b1;
        e.if_id_wr = 1'b1;
      end
      if (pclr) begin
        m_stall_cnt = 0;
        m_flush_cnt = 0;
      end else begin
        if (stall_ev && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (flush_ev && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkField(input string name, input logic [15:0] act,
                            input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("pc_wr", 16'(pc_wr), 16'(e.pc_wr));
    checkField("if_id_wr", 16'(if_id_wr), 16'(e.if_id_wr));
    checkField("if_id_flush", 16'(if_id_flush), 16'(e.if_id_flush));
    checkField("id_ex_bubble", 16'(id_ex_bubble), 16'(e.id_ex_bubble));
    checkField("pipe_hold", 16'(pipe_hold), 16'(e.pipe_hold));
    checkField("stall_cnt", 16'(stall_cnt), 16'(e.stall_cnt));
    checkField("flush_cnt", 16'(flush_cnt), 16'(e.flush_cnt));
  endtask

  // Monitor: outputs are combinational, so sample mid-low-phase each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    // Reset held three cycles, then plain running.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use hazard on rs for one cycle, then the load leaves EX.
    applyStimulus(0, 3, 0, 1, 0, 1, 3, 0, 0, 0);
    idle(4);
    // Hazard on rt.
    applyStimulus(0, 1, 5, 0, 1, 1, 5, 0, 0, 0);
    idle(4);
    // No hazard: destination reg 0, or source not used.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 1, 3, 0, 0, 0);
    idle(1);
    // Taken branch pulse.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // Hazard with mem_busy for two cycles in the middle of the stall.
    applyStimulus(0, 2, 0, 1, 0, 1, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // Hazard and branch together, then reset during the flush.
    applyStimulus(0, 4, 4, 1, 1, 1, 4, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Branch arriving mid load-use stall.
    applyStimulus(0, 6, 0, 1, 0, 1, 6, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // Counter clear coinciding with an increment.
    applyStimulus(0, 7, 0, 1, 0, 1, 7, 0, 0, 1);
    idle(4);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic mb;
      mb = ($urandom_range(0, 99) < 15);
      applyStimulus(($urandom_range(0, 99) < 2),
                    REG_AW'($urandom), REG_AW'($urandom),
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 99) < 50), REG_AW'($urandom),
                    ($urandom_range(0, 99) < 10), mb,
                    (!mb && $urandom_range(0, 99) < 2));
    end
    idle(2);
    @(negedge clk);
    #4;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
